not_checker: RTL and testbench

- Self-checking response monitor for the inverter design (not_db).
- Watches the inverter input x and output y. After each input change and a settle window, it checks y == ~x and counts samples and mismatches.
- Sits beside the inverter in simulation or on-chip self-test, at the observing end where the stimulus driver is the driving end.
- Reports done and pass/fail so benches and hardware self-test need no waveform inspection.

---
 rtl/not_pkg.sv | 21 ++
 rtl/not_settle_timer.sv | 29 ++
 rtl/not_checker.sv | 150 +++++++++++++++
 tb/tb_not_checker.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/not_pkg.sv
// Shared state encoding and default constants for the inverter response checker.
package not_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        WATCH  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int DEF_SETTLE_CYCLES  = 2;
    localparam int DEF_N_SAMPLES      = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1000;
    localparam int DEF_CNT_W          = 8;

    // Settle windows are limited to 1..255 cycles, so 8 bits always suffice.
    localparam int SETTLE_W = 8;

endpackage

// File: rtl/not_settle_timer.sv
// Loadable down-counter with a zero flag; times the settle window after an x change.
module not_settle_timer
    import not_pkg::*;
#(
    parameter int W = SETTLE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/not_checker.sv
// Response monitor for the inverter: after each x change and a settle window it
// checks y == ~x, counting samples and mismatches, and reports done/pass/timeout.
module not_checker
    import not_pkg::*;
#(
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int N_SAMPLES      = DEF_N_SAMPLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             x,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             first_err_x
);

    localparam int                  TO_W        = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    N_LAST      = CNT_W'(N_SAMPLES);

    state_t           state;
    state_t           state_next;
    logic             x_prev;
    logic             x_changed;
    logic [TO_W-1:0]  to_cnt;
    logic [CNT_W-1:0] sample_inc;
    logic             settle_load;
    logic             settle_dec;
    logic             settle_zero;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign x_changed  = x ^ x_prev;
    assign sample_inc = sample_cnt + 1'b1;

    not_settle_timer #(
        .W(SETTLE_W)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (settle_load),
        .load_val (SETTLE_LOAD),
        .dec      (settle_dec),
        .zero     (settle_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next inside {ARM, SETTLE, CHECK, WATCH});
            done  <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next  = state;
        settle_load = 1'b0;
        settle_dec  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) state_next = ARM;
            end
            ARM: begin
                settle_load = 1'b1;
                state_next  = SETTLE;
            end
            SETTLE: begin
                // A change on the cycle the window expires still restarts it.
                if (x_changed) begin
                    settle_load = 1'b1;
                end else if (settle_zero) begin
                    state_next = CHECK;
                end else begin
                    settle_dec = 1'b1;
                end
            end
            CHECK: begin
                state_next = (sample_inc == N_LAST) ? DONE : WATCH;
            end
            WATCH: begin
                if (x_changed) begin
                    settle_load = 1'b1;
                    state_next  = SETTLE;
                end else if (to_cnt == TO_LAST) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_prev      <= 1'b0;
            to_cnt      <= '0;
            timeout     <= 1'b0;
            err_cnt     <= '0;
            sample_cnt  <= '0;
            first_err_x <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    x_prev     <= x;
                    err_cnt    <= '0;
                    sample_cnt <= '0;
                    timeout    <= 1'b0;
                end
                SETTLE: begin
                    if (x_changed) x_prev <= x;
                end
                CHECK: begin
                    sample_cnt <= sample_inc;
                    to_cnt     <= '0;
                    // y == x is exactly the y != ~x mismatch for single bits.
                    if (y == x) begin
                        err_cnt <= sat_inc(err_cnt);
                        if (err_cnt == '0) first_err_x <= x;
                    end
                end
                WATCH: begin
                    if (x_changed) begin
                        x_prev <= x;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (to_cnt == TO_LAST) timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pass = done & (err_cnt == '0) & ~timeout;

endmodule

// File: tb/tb_not_checker.sv
// Randomized scoreboard bench for not_checker: a run model predicts each run's result,
// a monitor compares it when done rises.
module tb_not_checker;

    localparam int S       = 2;
    localparam int N       = 3;
    localparam int TO      = 20;
    localparam int CW      = 2;
    localparam int ERR_MAX = (1 << CW) - 1;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic          x     = 1'b0;
    logic          y     = 1'b1;
    logic          busy;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] sample_cnt;
    logic          first_err_x;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int samples;
        int errs;
        bit fex;
        bit tmo;
        bit pass;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    not_checker #(
        .SETTLE_CYCLES (S),
        .N_SAMPLES     (N),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x          (x),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .err_cnt    (err_cnt),
        .sample_cnt (sample_cnt),
        .first_err_x(first_err_x)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inverter behaviour per mode: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 buffer (always wrong).
    function automatic logic yfun(input int mode, input logic xv);
        case (mode)
            0:       return ~xv;
            1:       return 1'b0;
            2:       return 1'b1;
            default: return xv;
        endcase
    endfunction

    function automatic int pick_mode();
        if ($urandom_range(0, 3) != 0) return 0;
        return int'($urandom_range(1, 3));
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},        int'(busy),        0);
        check({tag, "_done"},        int'(done),        0);
        check({tag, "_pass"},        int'(pass),        0);
        check({tag, "_timeout"},     int'(timeout),     0);
        check({tag, "_err_cnt"},     int'(err_cnt),     0);
        check({tag, "_sample_cnt"},  int'(sample_cnt),  0);
        check({tag, "_first_err_x"}, int'(first_err_x), 0);
    endtask

    // One run of n_tx samples: the initial level, then (n_tx-1) glitchy toggle bursts.
    // Fewer than N samples means the run must end by timeout.
    task automatic run(input int n_tx, input int fmode);
        exp_t e;
        int   mode;
        logic xv;
        int   c;
        int   t_last;
        int   wrong;
        bit   have_err;
        bit   fex;
        int   m;

        wrong    = 0;
        have_err = 0;
        fex      = 0;
        mode     = (fmode >= 0) ? fmode : pick_mode();
        xv       = 1'($urandom_range(0, 1));
        x        = xv;
        y        = yfun(mode, xv);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        c        = cyc + S + 2;
        if (y != ~xv) begin
            wrong++;
            have_err = 1;
            fex      = xv;
        end

        for (int j = 1; j < n_tx; j++) begin
            while (cyc < c) tick();
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            mode   = (fmode >= 0) ? fmode : pick_mode();
            m      = int'($urandom_range(1, 3));
            t_last = 0;
            for (int i = 0; i < m; i++) begin
                xv     = ~xv;
                x      = xv;
                y      = yfun(mode, xv);
                t_last = cyc + 1;
                if (i < m - 1) repeat ($urandom_range(1, S)) tick();
            end
            c = t_last + S + 1;
            if (y != ~xv) begin
                wrong++;
                if (!have_err) fex = xv;
                have_err = 1;
            end
        end

        e.samples = n_tx;
        e.errs    = (wrong > ERR_MAX) ? ERR_MAX : wrong;
        e.fex     = fex;
        e.tmo     = (n_tx < N);
        e.pass    = (wrong == 0) && (n_tx == N);
        e.cyc     = (n_tx == N) ? c : c + TO;
        exp_q.push_back(e);

        for (int k = 0; k < TO + 40 && done !== 1'b1; k++) tick();
        check("run_done", int'(done), 1);
    endtask

    task automatic reset_mid_run();
        int c;
        x     = 1'b1;
        y     = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        c     = cyc + S + 2;
        while (cyc < c) tick();
        check("pre_rst_err_cnt",     int'(err_cnt),     1);
        check("pre_rst_sample_cnt",  int'(sample_cnt),  1);
        check("pre_rst_first_err_x", int'(first_err_x), 1);
        x = 1'b0;
        tick();
        check("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        tick();
        #2 rst = 1'b0;
        tick();
        check_all_zero("post_rst");
    endtask

    initial begin : monitor
        logic done_d;
        exp_t e;
        done_d = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1 && done_d !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: done rose at cycle %0d with no run outstanding", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle",   cyc,              e.cyc);
                    check("sample_cnt",   int'(sample_cnt), e.samples);
                    check("err_cnt",      int'(err_cnt),    e.errs);
                    check("timeout",      int'(timeout),    int'(e.tmo));
                    check("pass",         int'(pass),       int'(e.pass));
                    check("busy_at_done", int'(busy),       0);
                    if (e.errs != 0) check("first_err_x", int'(first_err_x), int'(e.fex));
                end
            end
            done_d = done;
        end
    end

    initial begin : stimulus
        #1 rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        #2 rst = 1'b0;
        tick();

        run(N, 0);
        run(N, 1);
        run(N, 3);
        run(1, 0);
        run(2, 2);
        reset_mid_run();
        run(N, 0);

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) run(int'($urandom_range(1, N - 1)), -1);
            else                           run(N, -1);
        end

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
